// File: rtl/bridge_pkg.sv
// Shared definitions for the ASCII-hex UART bridge: FSM states, command characters
// and hex-digit helpers used by both receive and transmit sides.
package bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ADDR,
        S_GET_DATA,
        S_GET_CNT,
        S_GET_TERM,
        S_EMIT,
        S_BURST
    } state_t;

    typedef enum logic [1:0] {
        K_READ,
        K_WRITE,
        K_BURST
    } kind_t;

    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_B = 8'h42;
    localparam logic [7:0] CR   = 8'h0D;
    localparam logic [7:0] LF   = 8'h0A;

    function automatic logic is_ascii_hex(input logic [7:0] c, input logic lowercase_ok);
        logic dig;
        logic upper;
        logic lower;
        dig   = (c >= 8'h30) && (c <= 8'h39);
        upper = (c >= 8'h41) && (c <= 8'h46);
        lower = (c >= 8'h61) && (c <= 8'h66);
        return dig || upper || (lowercase_ok && lower);
    endfunction

    // Assumes c already passed is_ascii_hex; digits, 'A'-'F' and 'a'-'f' all map to 0-15.
    function automatic logic [3:0] from_ascii_hex(input logic [7:0] c);
        logic [7:0] v;
        if (c <= 8'h39)      v = c - 8'h30;
        else if (c <= 8'h46) v = c - 8'h37;
        else                 v = c - 8'h57;
        return v[3:0];
    endfunction

endpackage

// File: rtl/bridge_rx_burst.sv
// ASCII-hex command parser: R/W/B commands from uart_rx turned into bus transactions,
// with backpressure, burst reads, inter-byte timeout and error counting.
module bridge_rx_burst #(
    parameter int unsigned ADDR_DIGITS    = 4,
    parameter int unsigned DATA_DIGITS    = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned LOWERCASE_OK   = 1,
    parameter int unsigned BURST_EN       = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [7:0]                 data_i,
    input  logic                       valid_i,
    output logic [4*ADDR_DIGITS-1:0]   addr_o,
    output logic [4*DATA_DIGITS-1:0]   data_o,
    output logic                       rw_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       busy_o,
    output logic                       err_o,
    output logic [7:0]                 err_cnt_o
);
    import bridge_pkg::*;

    localparam int unsigned ADDR_W  = 4 * ADDR_DIGITS;
    localparam int unsigned DATA_W  = 4 * DATA_DIGITS;
    localparam int unsigned MAX_DIG = (ADDR_DIGITS > DATA_DIGITS)
                                    ? ((ADDR_DIGITS > 2) ? ADDR_DIGITS : 2)
                                    : ((DATA_DIGITS > 2) ? DATA_DIGITS : 2);
    localparam int unsigned DIG_W   = $clog2(MAX_DIG + 1);
    localparam int unsigned TMO_W   = 32;

    state_t              state_q, state_d;
    kind_t               kind_q, kind_d;
    logic [DIG_W-1:0]    dig_q, dig_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_d;

    logic                valid_d, busy_d, rw_d;
    logic [ADDR_W-1:0]   addr_out_d;
    logic [DATA_W-1:0]   data_out_d;

    logic                xfer;
    logic                in_get;
    logic                tmo_hit;
    logic                hex;
    logic [3:0]          nib;
    logic                is_start;
    logic                last_dig;

    assign xfer    = valid_o && ready_i;
    assign in_get  = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA)
                  || (state_q == S_GET_CNT)  || (state_q == S_GET_TERM);
    // A byte in the same cycle as expiry wins over the timeout.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && in_get && !valid_i
                  && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign hex     = is_ascii_hex(data_i, LOWERCASE_OK != 0);
    assign nib     = from_ascii_hex(data_i);
    assign is_start = (data_i == CH_R) || (data_i == CH_W)
                   || ((BURST_EN != 0) && (data_i == CH_B));
    assign last_dig = ((state_q == S_GET_ADDR) && (dig_q == DIG_W'(ADDR_DIGITS - 1)))
                   || ((state_q == S_GET_DATA) && (dig_q == DIG_W'(DATA_DIGITS - 1)))
                   || ((state_q == S_GET_CNT)  && (dig_q == DIG_W'(1)));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_READ;
            dig_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            dig_q   <= dig_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        dig_d   = dig_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        tmo_d   = (valid_i || !in_get) ? '0 : tmo_q + TMO_W'(1);

        unique case (state_q)
            S_IDLE: begin
                if (valid_i && is_start) begin
                    state_d = S_GET_ADDR;
                    kind_d  = (data_i == CH_R) ? K_READ
                            : (data_i == CH_W) ? K_WRITE : K_BURST;
                    dig_d   = '0;
                    addr_d  = '0;
                    data_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_GET_ADDR, S_GET_DATA, S_GET_CNT: begin
                if (tmo_hit || (valid_i && !hex)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else if (valid_i) begin
                    dig_d = dig_q + DIG_W'(1);
                    if (state_q == S_GET_ADDR)      addr_d = ADDR_W'({addr_q, nib});
                    else if (state_q == S_GET_DATA) data_d = DATA_W'({data_q, nib});
                    else                            cnt_d  = {cnt_q[3:0], nib};
                    if (last_dig) begin
                        dig_d = '0;
                        if (state_q == S_GET_ADDR && kind_q == K_WRITE)      state_d = S_GET_DATA;
                        else if (state_q == S_GET_ADDR && kind_q == K_BURST) state_d = S_GET_CNT;
                        else                                                 state_d = S_GET_TERM;
                    end
                end
            end
            S_GET_TERM: begin
                if (valid_i) begin
                    if (data_i == CR || data_i == LF) begin
                        if (kind_q != K_BURST)  state_d = S_EMIT;
                        else if (cnt_q == 8'd0) state_d = S_IDLE;
                        else                    state_d = S_BURST;
                    end else begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end
            end
            S_EMIT: begin
                if (xfer)    state_d = S_IDLE;
                if (valid_i) err_d   = 1'b1;
            end
            S_BURST: begin
                if (xfer) begin
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) state_d = S_IDLE;
                end
                if (valid_i) err_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from next state; bus fields forced to 0 when not valid
    always_comb begin
        valid_d    = (state_d == S_EMIT) || (state_d == S_BURST);
        busy_d     = (state_d != S_IDLE);
        rw_d       = valid_d && (state_d == S_EMIT) && (kind_d == K_WRITE);
        addr_out_d = valid_d ? addr_d : '0;
        data_out_d = rw_d ? data_d : '0;
    end

    // Registered outputs and saturating error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o   <= 1'b0;
            busy_o    <= 1'b0;
            rw_o      <= 1'b0;
            addr_o    <= '0;
            data_o    <= '0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            valid_o <= valid_d;
            busy_o  <= busy_d;
            rw_o    <= rw_d;
            addr_o  <= addr_out_d;
            data_o  <= data_out_d;
            err_o   <= err_d;
            if (err_d && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
        end
    end

endmodule

// File: tb/tb_bridge_rx_burst.sv
// Directed bench for bridge_rx_burst: a main instance (timeout 100, lowercase on)
// and a second instance with lowercase hex disabled sharing the byte stream.
module tb_bridge_rx_burst;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic        rw;
    } xfer_t;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready;
    logic [15:0] addr_o, data_o;
    logic        rw_o, valid_o, busy_o, err_o;
    logic [7:0]  err_cnt_o;

    logic [15:0] addr_lc, data_lc;
    logic        rw_lc, valid_lc, busy_lc, err_lc;
    logic [7:0]  err_cnt_lc;

    int n_cmp;
    int n_fail;
    int err_n;
    int err_n_lc;
    xfer_t xq[$];
    xfer_t xq_lc[$];

    bridge_rx_burst #(
        .ADDR_DIGITS(4), .DATA_DIGITS(4), .TIMEOUT_CYCLES(100),
        .LOWERCASE_OK(1), .BURST_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(addr_o), .data_o(data_o), .rw_o(rw_o), .valid_o(valid_o),
        .ready_i(ready), .busy_o(busy_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    bridge_rx_burst #(
        .ADDR_DIGITS(4), .DATA_DIGITS(4), .TIMEOUT_CYCLES(0),
        .LOWERCASE_OK(0), .BURST_EN(1)
    ) dut_lc (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
        .addr_o(addr_lc), .data_o(data_lc), .rw_o(rw_lc), .valid_o(valid_lc),
        .ready_i(1'b1), .busy_o(busy_lc), .err_o(err_lc), .err_cnt_o(err_cnt_lc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at posedge+1, so the negedge sees the values the next posedge will use.
    always @(negedge clk) begin
        if (valid_o && ready) xq.push_back('{addr_o, data_o, rw_o});
        if (valid_lc)         xq_lc.push_back('{addr_lc, data_lc, rw_lc});
        if (err_o)  err_n++;
        if (err_lc) err_n_lc++;
    end

    task automatic send_byte(input logic [7:0] b);
        data_i  = b;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; ready = 1'b0; data_i = 8'h00; valid_i = 1'b0;
        #2;
        idle(3);
        n_cmp++; if (valid_o !== 1'b0)    begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (busy_o !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        n_cmp++; if (err_o !== 1'b0)      begin n_fail++; $display("FAIL reset_err: got %b want 0", err_o); end
        n_cmp++; if (err_cnt_o !== 8'd0)  begin n_fail++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt_o); end
        n_cmp++; if ({addr_o, data_o, rw_o} !== 33'd0) begin n_fail++; $display("FAIL reset_bus: got %h/%h/%b want 0", addr_o, data_o, rw_o); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read;
        xq.delete();
        ready = 1'b1;
        send_str("R1234");
        send_byte(8'h0D);
        n_cmp++; if (valid_o !== 1'b1) begin n_fail++; $display("FAIL read_latency: valid_o got %b want 1", valid_o); end
        idle(3);
        n_cmp++; if (xq.size() !== 1) begin n_fail++; $display("FAIL read_count: got %0d want 1", xq.size()); end
        else begin
            n_cmp++; if ({xq[0].a, xq[0].d, xq[0].rw} !== {16'h1234, 16'h0000, 1'b0})
                begin n_fail++; $display("FAIL read_fields: got %h/%h/%b want 1234/0000/0", xq[0].a, xq[0].d, xq[0].rw); end
        end
        n_cmp++; if (err_cnt_o !== 8'd0) begin n_fail++; $display("FAIL read_errcnt: got %0d want 0", err_cnt_o); end
        n_cmp++; if (busy_o !== 1'b0)    begin n_fail++; $display("FAIL read_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_lowercase;
        int e0;
        xq.delete(); xq_lc.delete();
        e0 = err_n_lc;
        ready = 1'b1;
        send_str("W00ab7F9E");
        send_byte(8'h0A);
        idle(3);
        n_cmp++; if (xq.size() !== 1) begin n_fail++; $display("FAIL lower_count: got %0d want 1", xq.size()); end
        else begin
            n_cmp++; if ({xq[0].a, xq[0].d, xq[0].rw} !== {16'h00AB, 16'h7F9E, 1'b1})
                begin n_fail++; $display("FAIL lower_fields: got %h/%h/%b want 00ab/7f9e/1", xq[0].a, xq[0].d, xq[0].rw); end
        end
        n_cmp++; if (err_n_lc - e0 !== 1)  begin n_fail++; $display("FAIL nolower_err: got %0d pulses want 1", err_n_lc - e0); end
        n_cmp++; if (xq_lc.size() !== 0)   begin n_fail++; $display("FAIL nolower_xfer: got %0d want 0", xq_lc.size()); end
        n_cmp++; if (err_cnt_lc !== 8'd1)  begin n_fail++; $display("FAIL nolower_errcnt: got %0d want 1", err_cnt_lc); end
    endtask

    task automatic test_backpressure;
        int stable;
        xq.delete();
        stable = 0;
        ready = 1'b0;
        send_str("W0001FFFF");
        send_byte(8'h0D);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) ready = 1'b1;
            if (valid_o === 1'b1 && addr_o === 16'h0001 && data_o === 16'hFFFF && rw_o === 1'b1)
                stable++;
            @(posedge clk); #1;
        end
        ready = 1'b0;
        n_cmp++; if (stable !== 6)       begin n_fail++; $display("FAIL bp_stable: got %0d cycles want 6", stable); end
        n_cmp++; if (valid_o !== 1'b0)   begin n_fail++; $display("FAIL bp_drop: valid_o got %b want 0", valid_o); end
        idle(2);
        n_cmp++; if (xq.size() !== 1)    begin n_fail++; $display("FAIL bp_count: got %0d want 1", xq.size()); end
        n_cmp++; if ({addr_o, data_o, rw_o} !== 33'd0) begin n_fail++; $display("FAIL bp_idle_bus: got %h/%h/%b want 0", addr_o, data_o, rw_o); end
    endtask

    task automatic test_burst;
        logic [4:0] pat;
        logic [15:0] exp_a [3];
        pat = 5'b10101;
        exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000;
        xq.delete();
        ready = 1'b0;
        send_str("BFFFE03");
        send_byte(8'h0D);
        n_cmp++; if ({valid_o, busy_o} !== 2'b11) begin n_fail++; $display("FAIL burst_start: valid/busy got %b%b want 11", valid_o, busy_o); end
        for (int i = 0; i < 5; i++) begin
            ready = pat[4-i];
            @(posedge clk); #1;
        end
        ready = 1'b0;
        n_cmp++; if ({valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL burst_end: valid/busy got %b%b want 00", valid_o, busy_o); end
        n_cmp++; if (xq.size() !== 3) begin n_fail++; $display("FAIL burst_count: got %0d want 3", xq.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if ({xq[i].a, xq[i].d, xq[i].rw} !== {exp_a[i], 16'h0000, 1'b0})
                    begin n_fail++; $display("FAIL burst_beat%0d: got %h/%h/%b want %h/0000/0", i, xq[i].a, xq[i].d, xq[i].rw, exp_a[i]); end
            end
        end
    endtask

    task automatic test_burst_zero;
        int e0;
        xq.delete();
        e0 = err_n;
        ready = 1'b1;
        send_str("B123400");
        send_byte(8'h0D);
        idle(3);
        n_cmp++; if (xq.size() !== 0)          begin n_fail++; $display("FAIL bzero_xfer: got %0d want 0", xq.size()); end
        n_cmp++; if (err_n - e0 !== 0)         begin n_fail++; $display("FAIL bzero_err: got %0d want 0", err_n - e0); end
        n_cmp++; if ({valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL bzero_state: got %b%b want 00", valid_o, busy_o); end
    endtask

    task automatic test_timeout;
        int e0;
        xq.delete();
        e0 = err_n;
        ready = 1'b1;
        send_str("R12");
        idle(90);
        n_cmp++; if (err_n - e0 !== 0)  begin n_fail++; $display("FAIL tmo_early: got %0d pulses want 0", err_n - e0); end
        n_cmp++; if (busy_o !== 1'b1)   begin n_fail++; $display("FAIL tmo_busy: got %b want 1", busy_o); end
        idle(15);
        n_cmp++; if (err_n - e0 !== 1)  begin n_fail++; $display("FAIL tmo_fire: got %0d pulses want 1", err_n - e0); end
        n_cmp++; if (err_cnt_o !== 8'd1) begin n_fail++; $display("FAIL tmo_errcnt: got %0d want 1", err_cnt_o); end
        n_cmp++; if (busy_o !== 1'b0)   begin n_fail++; $display("FAIL tmo_idle: got %b want 0", busy_o); end
        send_str("R0005");
        send_byte(8'h0D);
        idle(3);
        n_cmp++; if (xq.size() !== 1) begin n_fail++; $display("FAIL tmo_next_count: got %0d want 1", xq.size()); end
        else begin
            n_cmp++; if (xq[0].a !== 16'h0005) begin n_fail++; $display("FAIL tmo_next_addr: got %h want 0005", xq[0].a); end
        end
    endtask

    task automatic test_drop_byte;
        int e0;
        xq.delete();
        e0 = err_n;
        ready = 1'b0;
        send_str("W0010BEEF");
        send_byte(8'h0D);
        send_byte(8'h58);
        idle(2);
        n_cmp++; if ({valid_o, addr_o, data_o} !== {1'b1, 16'h0010, 16'hBEEF})
            begin n_fail++; $display("FAIL drop_hold: got %b/%h/%h want 1/0010/beef", valid_o, addr_o, data_o); end
        n_cmp++; if (err_n - e0 !== 1)   begin n_fail++; $display("FAIL drop_err: got %0d pulses want 1", err_n - e0); end
        n_cmp++; if (err_cnt_o !== 8'd2) begin n_fail++; $display("FAIL drop_errcnt: got %0d want 2", err_cnt_o); end
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        idle(2);
        n_cmp++; if (xq.size() !== 1) begin n_fail++; $display("FAIL drop_count: got %0d want 1", xq.size()); end
    endtask

    task automatic test_err_saturate;
        ready = 1'b0;
        send_str("R0000");
        send_byte(8'h0D);
        repeat (260) send_byte(8'h5A);
        idle(2);
        n_cmp++; if (err_cnt_o !== 8'd255) begin n_fail++; $display("FAIL sat_errcnt: got %0d want 255", err_cnt_o); end
        n_cmp++; if (valid_o !== 1'b1)     begin n_fail++; $display("FAIL sat_hold: valid_o got %b want 1", valid_o); end
        ready = 1'b1;
        idle(3);
        ready = 1'b0;
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL sat_done: busy got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid_burst;
        ready = 1'b0;
        send_str("BFFFE03");
        send_byte(8'h0D);
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({valid_o, busy_o} !== 2'b00) begin n_fail++; $display("FAIL arst_state: valid/busy got %b%b want 00", valid_o, busy_o); end
        n_cmp++; if (err_cnt_o !== 8'd0)         begin n_fail++; $display("FAIL arst_errcnt: got %0d want 0", err_cnt_o); end
        n_cmp++; if (addr_o !== 16'h0000)        begin n_fail++; $display("FAIL arst_addr: got %h want 0000", addr_o); end
        idle(2);
        rst_n = 1'b1;
        idle(1);
        xq.delete();
        ready = 1'b1;
        send_str("R0001");
        send_byte(8'h0D);
        idle(3);
        n_cmp++; if (xq.size() !== 1) begin n_fail++; $display("FAIL arst_next_count: got %0d want 1", xq.size()); end
        else begin
            n_cmp++; if ({xq[0].a, xq[0].rw} !== {16'h0001, 1'b0}) begin n_fail++; $display("FAIL arst_next_fields: got %h/%b want 0001/0", xq[0].a, xq[0].rw); end
        end
        n_cmp++; if (err_cnt_o !== 8'd0) begin n_fail++; $display("FAIL arst_next_errcnt: got %0d want 0", err_cnt_o); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0; err_n = 0; err_n_lc = 0;
        test_reset();
        test_read();
        test_lowercase();
        test_backpressure();
        test_burst();
        test_burst_zero();
        test_timeout();
        test_drop_byte();
        test_err_saturate();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
